// File: rtl/fp_cmp_pkg.sv
// Shared encodings for the FloPoCo comparator: compare modes, exception codes
// and the canonical NaN pattern.
package fp_cmp_pkg;

    typedef enum logic [2:0] {
        CMP_LT  = 3'd0,
        CMP_LE  = 3'd1,
        CMP_EQ  = 3'd2,
        CMP_NE  = 3'd3,
        CMP_GT  = 3'd4,
        CMP_GE  = 3'd5,
        CMP_MIN = 3'd6,
        CMP_MAX = 3'd7
    } cmp_mode_e;

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    localparam int unsigned MaxW = 64;

    // Callers truncate to their operand width W = we+wf+3.
    function automatic logic [MaxW-1:0] canon_nan(input int unsigned we, input int unsigned wf);
        return {{(MaxW-2){1'b0}}, EXC_NAN} << (we + wf + 1);
    endfunction

endpackage

// File: rtl/fp_key_decode.sv
// Splits a FloPoCo operand into an unsigned magnitude key plus sign/zero/NaN flags.
// Zeros get key 0 so that +0 and -0 compare equal.
module fp_key_decode
    import fp_cmp_pkg::*;
#(
    parameter int unsigned WE = 3,
    parameter int unsigned WF = 11
) (
    input  logic [WE+WF+2:0] x,
    output logic [WE+WF+1:0] key,
    output logic             sign,
    output logic             is_zero,
    output logic             is_nan
);

    logic [1:0] exc;

    always_comb begin
        exc     = x[WE+WF+2:WE+WF+1];
        sign    = x[WE+WF];
        is_zero = (exc == EXC_ZERO);
        is_nan  = (exc == EXC_NAN);
        key     = is_zero ? '0 : {exc, x[WE+WF-1:0]};
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage valid/ready FloPoCo comparator with eight modes, NaN handling,
// tag pass-through and a saturating unordered-event counter.
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int unsigned WE    = 3,
    parameter int unsigned WF    = 11,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WE+WF+2:0] in_a,
    input  logic [WE+WF+2:0] in_b,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_flag,
    output logic [WE+WF+2:0] out_value,
    output logic             out_unordered,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] unord_cnt
);

    localparam int unsigned W  = WE + WF + 3;
    localparam int unsigned KW = WE + WF + 2;
    localparam logic [W-1:0] CanonNan = W'(canon_nan(WE, WF));

    logic [KW-1:0] a_key, b_key;
    logic          a_sign, b_sign, a_zero, b_zero, a_nan, b_nan;

    fp_key_decode #(.WE(WE), .WF(WF)) u_dec_a (
        .x(in_a), .key(a_key), .sign(a_sign), .is_zero(a_zero), .is_nan(a_nan)
    );
    fp_key_decode #(.WE(WE), .WF(WF)) u_dec_b (
        .x(in_b), .key(b_key), .sign(b_sign), .is_zero(b_zero), .is_nan(b_nan)
    );

    logic s1_en, s2_en;
    logic s1_valid_q;
    logic [KW-1:0] a_key_q, b_key_q;
    logic a_sign_q, b_sign_q, a_zero_q, b_zero_q, a_nan_q, b_nan_q;
    logic [W-1:0] a_q, b_q;
    cmp_mode_e mode_q;
    logic [TAG_W-1:0] tag_q;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_key_q    <= '0;
            b_key_q    <= '0;
            a_sign_q   <= 1'b0;
            b_sign_q   <= 1'b0;
            a_zero_q   <= 1'b0;
            b_zero_q   <= 1'b0;
            a_nan_q    <= 1'b0;
            b_nan_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= CMP_LT;
            tag_q      <= '0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                a_key_q  <= a_key;
                b_key_q  <= b_key;
                a_sign_q <= a_sign;
                b_sign_q <= b_sign;
                a_zero_q <= a_zero;
                b_zero_q <= b_zero;
                a_nan_q  <= a_nan;
                b_nan_q  <= b_nan;
                a_q      <= in_a;
                b_q      <= in_b;
                mode_q   <= cmp_mode_e'(in_mode);
                tag_q    <= in_tag;
            end
        end
    end

    logic unord, both_zero, sign_diff, lt, eq, gt, sel_a, flag_d;
    logic [W-1:0] value_d;

    always_comb begin
        unord     = a_nan_q || b_nan_q;
        both_zero = a_zero_q && b_zero_q;
        sign_diff = (a_sign_q ^ b_sign_q) && !both_zero;
        eq        = !sign_diff && (a_key_q == b_key_q);
        // Negative magnitudes order in reverse of their keys.
        if (sign_diff)     lt = a_sign_q;
        else if (a_sign_q) lt = a_key_q > b_key_q;
        else               lt = a_key_q < b_key_q;
        gt      = !lt && !eq;
        sel_a   = (mode_q == CMP_MIN) ? (lt || eq) : (gt || eq);
        flag_d  = 1'b0;
        value_d = a_q;
        case (mode_q)
            CMP_LT: flag_d = lt && !unord;
            CMP_LE: flag_d = (lt || eq) && !unord;
            CMP_EQ: flag_d = eq && !unord;
            CMP_NE: flag_d = !eq || unord;
            CMP_GT: flag_d = gt && !unord;
            CMP_GE: flag_d = (gt || eq) && !unord;
            default: begin
                if (a_nan_q && b_nan_q) begin
                    flag_d  = 1'b0;
                    value_d = CanonNan;
                end else if (a_nan_q) begin
                    flag_d  = 1'b0;
                    value_d = b_q;
                end else if (b_nan_q) begin
                    flag_d  = 1'b1;
                    value_d = a_q;
                end else begin
                    flag_d  = sel_a;
                    value_d = sel_a ? a_q : b_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_flag      <= 1'b0;
            out_value     <= '0;
            out_unordered <= 1'b0;
            out_tag       <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out_flag      <= flag_d;
                out_value     <= value_d;
                out_unordered <= unord;
                out_tag       <= tag_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unord_cnt <= '0;
        end else if (in_valid && in_ready && (a_nan || b_nan) && !(&unord_cnt)) begin
            unord_cnt <= unord_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Scoreboard bench for fp_compare_pipe: directed vectors, backpressure and counter saturation.
module tb_fp_compare_pipe;
    import fp_cmp_pkg::*;

    localparam int unsigned WE = 3;
    localparam int unsigned WF = 11;
    localparam int unsigned W  = 17;
    localparam int unsigned TW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic [2:0]    in_mode = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid, out_ready, out_flag, out_unordered;
    logic [W-1:0]  out_value;
    logic [TW-1:0] out_tag;
    logic [15:0]   unord_cnt;

    logic          sat_in_ready, sat_out_valid, sat_out_flag, sat_out_unordered;
    logic [W-1:0]  sat_out_value;
    logic [TW-1:0] sat_out_tag;
    logic [1:0]    sat_cnt;

    fp_compare_pipe #(.WE(WE), .WF(WF), .TAG_W(TW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_flag(out_flag), .out_value(out_value),
        .out_unordered(out_unordered), .out_tag(out_tag), .unord_cnt(unord_cnt)
    );

    fp_compare_pipe #(.WE(WE), .WF(WF), .TAG_W(TW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .in_a(in_a),
        .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag), .out_valid(sat_out_valid),
        .out_ready(out_ready), .out_flag(sat_out_flag), .out_value(sat_out_value),
        .out_unordered(sat_out_unordered), .out_tag(sat_out_tag), .unord_cnt(sat_cnt)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   m;
        logic         f;
        logic [W-1:0] v;
        logic         u;
    } vec_t;

    typedef struct packed {
        logic          f;
        logic [W-1:0]  v;
        logic          u;
        logic [TW-1:0] t;
    } exp_t;

    vec_t tbl[22];
    exp_t sb[$];
    exp_t mon_e;
    int   nvec = 0, nerr = 0, inflight = 0, exp_cnt = 0, ready_mode = 0;

    function automatic logic [W-1:0] mk(input logic [1:0] exc, input logic s,
                                        input logic [2:0] e, input logic [10:0] f);
        return {exc, s, e, f};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send(input int i, input logic [TW-1:0] t);
        int   guard;
        logic done;
        guard = 0;
        done  = 1'b0;
        in_a = tbl[i].a; in_b = tbl[i].b; in_mode = tbl[i].m; in_tag = t; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({tbl[i].f, tbl[i].v, tbl[i].u, t});
                if (tbl[i].u) exp_cnt++;
                done = 1'b1;
            end else if (++guard > 100) begin
                nvec++; nerr++;
                $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(posedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            nvec++; nerr++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_counts(input string name);
        chk({name, "_cnt"}, 64'(unord_cnt), 64'(exp_cnt));
        chk({name, "_sat_cnt"}, 64'(sat_cnt), 64'((exp_cnt > 3) ? 3 : exp_cnt));
    endtask

    // Output ready pattern: 0 always, 1 random, 2 stalled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops on every output transfer, and checks in_ready against occupancy.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                inflight = 0;
            end else begin
                if (in_valid) chk("in_ready", 64'(in_ready), 64'((inflight < 2) || out_ready));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL unexpected_output: got tag %0h, required no output", out_tag);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("result{flag,value,unord,tag}",
                            64'({out_flag, out_value, out_unordered, out_tag}), 64'(mon_e));
                    end
                end
                inflight = inflight + int'(in_valid && in_ready) - int'(out_valid && out_ready);
            end
        end
    end

    initial begin
        logic [W-1:0] p1_5, n1_5, p0_5, n0_5, p2, n2, p1, pz, nz, ninf, nan, cnan;
        p1_5 = mk(2'b01, 1'b0, 3'd3, 11'h400);
        n1_5 = mk(2'b01, 1'b1, 3'd3, 11'h400);
        p0_5 = mk(2'b01, 1'b0, 3'd2, 11'h000);
        n0_5 = mk(2'b01, 1'b1, 3'd2, 11'h000);
        p2   = mk(2'b01, 1'b0, 3'd4, 11'h000);
        n2   = mk(2'b01, 1'b1, 3'd4, 11'h000);
        p1   = mk(2'b01, 1'b0, 3'd3, 11'h000);
        pz   = mk(2'b00, 1'b0, 3'd0, 11'h000);
        nz   = mk(2'b00, 1'b1, 3'd0, 11'h000);
        ninf = mk(2'b10, 1'b1, 3'd0, 11'h000);
        nan  = mk(2'b11, 1'b0, 3'd5, 11'h123);
        cnan = 17'h18000;
        tbl[0]  = '{n1_5, p0_5, CMP_LT,  1'b1, n1_5, 1'b0};
        tbl[1]  = '{p2,   p2,   CMP_LE,  1'b1, p2,   1'b0};
        tbl[2]  = '{p2,   p2,   CMP_EQ,  1'b1, p2,   1'b0};
        tbl[3]  = '{p2,   p2,   CMP_LT,  1'b0, p2,   1'b0};
        tbl[4]  = '{pz,   nz,   CMP_EQ,  1'b1, pz,   1'b0};
        tbl[5]  = '{pz,   nz,   CMP_LT,  1'b0, pz,   1'b0};
        tbl[6]  = '{ninf, p1,   CMP_LT,  1'b1, ninf, 1'b0};
        tbl[7]  = '{pz,   nz,   CMP_MIN, 1'b1, pz,   1'b0};
        tbl[8]  = '{nan,  p1,   CMP_LT,  1'b0, nan,  1'b1};
        tbl[9]  = '{nan,  p1,   CMP_GE,  1'b0, nan,  1'b1};
        tbl[10] = '{nan,  p1,   CMP_EQ,  1'b0, nan,  1'b1};
        tbl[11] = '{nan,  p1,   CMP_NE,  1'b1, nan,  1'b1};
        tbl[12] = '{nan,  p1,   CMP_MAX, 1'b0, p1,   1'b1};
        tbl[13] = '{nan,  nan,  CMP_MAX, 1'b0, cnan, 1'b1};
        tbl[14] = '{p1,   nan,  CMP_MIN, 1'b1, p1,   1'b1};
        tbl[15] = '{p2,   p0_5, CMP_GT,  1'b1, p2,   1'b0};
        tbl[16] = '{n2,   n0_5, CMP_GE,  1'b0, n2,   1'b0};
        tbl[17] = '{n1_5, p0_5, CMP_MAX, 1'b0, p0_5, 1'b0};
        tbl[18] = '{n1_5, p0_5, CMP_MIN, 1'b1, n1_5, 1'b0};
        tbl[19] = '{pz,   nz,   CMP_NE,  1'b0, pz,   1'b0};
        tbl[20] = '{nz,   pz,   CMP_GT,  1'b0, nz,   1'b0};
        tbl[21] = '{p1,   p1,   CMP_MAX, 1'b1, p1,   1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_flag", 64'(out_flag), 64'(0));
        chk("rst_out_value", 64'(out_value), 64'(0));
        chk("rst_unord_cnt", 64'(unord_cnt), 64'(0));
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Reset in the middle of a stream discards in-flight work.
        send(8, 4'hE);
        send(1, 4'hF);
        chk("mid_cnt_before_rst", 64'(unord_cnt), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_unord_cnt", 64'(unord_cnt), 64'(0));
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Latency: visible two cycles after acceptance.
        send(0, 4'h0);
        chk("latency_s1_only", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        chk("latency_s2_valid", 64'(out_valid), 64'(1));
        for (int i = 1; i < 22; i++) send(i, TW'(i));
        drain();
        chk_counts("directed");

        // Held backpressure: two stored, the third must wait.
        ready_mode = 2;
        send(15, 4'h1);
        send(16, 4'h2);
        fork
            send(17, 4'h3);
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("bp_full_in_ready", 64'(in_ready), 64'(0));
                chk("bp_full_out_tag", 64'(out_tag), 64'(4'h1));
                ready_mode = 0;
            end
        join
        drain();

        // Random backpressure stream.
        ready_mode = 1;
        for (int i = 0; i < 10; i++) send(i, TW'(i));
        drain();
        ready_mode = 0;
        drain();
        chk_counts("stream");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
